// File: rtl/regfile_wb_demux_pkg.sv
// Shared definitions for the write-back register file slice.
//   DATA_W   : register/data width
//   ADDR_W   : register-number width
//   NUM_REGS : stored registers R0..R14
//   REG_PC   : register number of the PC (R15), owned by fetch
//   CNT_W    : width of the accepted-write counter
package regfile_wb_demux_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 15;
  localparam int CNT_W    = 8;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t REG_PC = 4'd15;

endpackage

// File: rtl/regfile_wb_demux_if.sv
// Bus between the WB/ID stages and the register file.
//   master : WB/ID side, drives the write request and the two read addresses
//   slave  : register file, returns read data, PC-write error and write count
interface regfile_wb_demux_if
  import regfile_wb_demux_pkg::*;
();

  logic             wb_en;
  addr_t            wb_dest;
  data_t            wb_data;
  addr_t            rd_addr1;
  addr_t            rd_addr2;
  data_t            rd_data1;
  data_t            rd_data2;
  logic             wr_pc_err;
  logic [CNT_W-1:0] wr_count;

  modport master (
    output wb_en, wb_dest, wb_data, rd_addr1, rd_addr2,
    input  rd_data1, rd_data2, wr_pc_err, wr_count
  );

  modport slave (
    input  wb_en, wb_dest, wb_data, rd_addr1, rd_addr2,
    output rd_data1, rd_data2, wr_pc_err, wr_count
  );

endinterface

// File: rtl/regfile_wb_demux_dest_decoder.sv
// Destination decoder: write request plus register number to a one-hot
// write-enable vector. Bit 15 (PC) is never a real register; the top level
// uses it only to flag an illegal PC write.
//   en   : write request valid
//   dest : destination register number
//   we   : one-hot write enables, all zero when en is low
module dest_decoder_4to16
  import regfile_wb_demux_pkg::*;
(
  input  logic                 en,
  input  addr_t                dest,
  output logic [2**ADDR_W-1:0] we
);

  always_comb begin
    we = '0;
    if (en) we[dest] = 1'b1;
  end

endmodule

// File: rtl/regfile_wb_demux.sv
// Write-back register file: R0..R14 written from WB, two combinational read
// ports for ID. R15 reads as zero (decode muxes in the PC itself) and any
// write attempt to it sets a sticky error instead of changing state.
// Build option: define WB_BYPASS_EN to forward a same-cycle write to a read
// port addressing the same register (never for R15).
//   clk : core clock
//   rst : asynchronous reset, active high
//   bus : slave side of regfile_wb_demux_if
module regfile_wb_demux
  import regfile_wb_demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  regfile_wb_demux_if.slave bus
);

  logic [2**ADDR_W-1:0] we;
  data_t                regs [NUM_REGS];
  logic                 pc_err;
  logic [CNT_W-1:0]     count;
  data_t                rd1;
  data_t                rd2;

  dest_decoder_4to16 u_dec (
    .en   (bus.wb_en),
    .dest (bus.wb_dest),
    .we   (we)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      pc_err <= 1'b0;
      count  <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (we[i]) regs[i] <= bus.wb_data;
      end
      // Only real-register writes are counted; a PC write is rejected.
      if (|we[NUM_REGS-1:0]) count <= count + 1'b1;
      if (we[REG_PC]) pc_err <= 1'b1;
    end
  end

  always_comb begin
    rd1 = '0;
    if (bus.rd_addr1 != REG_PC) rd1 = regs[bus.rd_addr1];
`ifdef WB_BYPASS_EN
    // we is one-hot on the write target, so indexing it by the read address
    // tells us whether this port reads the register being written.
    if (we[bus.rd_addr1] && bus.rd_addr1 != REG_PC) rd1 = bus.wb_data;
`endif
  end

  always_comb begin
    rd2 = '0;
    if (bus.rd_addr2 != REG_PC) rd2 = regs[bus.rd_addr2];
`ifdef WB_BYPASS_EN
    if (we[bus.rd_addr2] && bus.rd_addr2 != REG_PC) rd2 = bus.wb_data;
`endif
  end

  assign bus.rd_data1  = rd1;
  assign bus.rd_data2  = rd2;
  assign bus.wr_pc_err = pc_err;
  assign bus.wr_count  = count;

endmodule

// File: tb/tb_regfile_wb_demux.sv
module tb_regfile_wb_demux;
  import regfile_wb_demux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_demux_if bus ();

  regfile_wb_demux dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        err;
    logic [7:0]  cnt;
    string       tag;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain array of the 16 architectural numbers, index 15 unused.
  logic [31:0] m_regs [16];
  logic        m_err;
  int          m_cnt;

  // Values currently driven by the bench.
  logic        cur_rst  = 1'b1;
  logic        cur_en   = 1'b0;
  logic [3:0]  cur_dest = '0;
  logic [31:0] cur_data = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [3:0] a);
    if (a == 4'd15) return 32'h0;
`ifdef WB_BYPASS_EN
    if (cur_en && cur_dest != 4'd15 && a == cur_dest) return cur_data;
`endif
    return m_regs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  // One clock of stimulus: retire last cycle's write into the model at the
  // edge, drive the new inputs, and queue what the read side should show.
  task automatic step(input logic r, input logic en, input logic [3:0] dest,
                      input logic [31:0] data, input logic [3:0] a1,
                      input logic [3:0] a2, input string tag);
    exp_t x;
    @(posedge clk);
    if (!cur_rst && cur_en) begin
      if (cur_dest == 4'd15) m_err = 1'b1;
      else begin
        m_regs[cur_dest] = cur_data;
        m_cnt = (m_cnt + 1) % 256;
      end
    end
    #1;
    cur_rst  = r;
    cur_en   = en;
    cur_dest = dest;
    cur_data = data;
    rst          = r;
    bus.wb_en    = en;
    bus.wb_dest  = dest;
    bus.wb_data  = data;
    bus.rd_addr1 = a1;
    bus.rd_addr2 = a2;
    if (r) model_clear();
    x.rd1 = exp_read(a1);
    x.rd2 = exp_read(a2);
    x.err = m_err;
    x.cnt = 8'(m_cnt);
    x.tag = tag;
    q.push_back(x);
  endtask

  // Monitor: the read side presents data every cycle; compare mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.tag, ".rd_data1"}, bus.rd_data1, e.rd1);
        check({e.tag, ".rd_data2"}, bus.rd_data2, e.rd2);
        check({e.tag, ".wr_pc_err"}, {31'h0, bus.wr_pc_err}, {31'h0, e.err});
        check({e.tag, ".wr_count"}, {24'h0, bus.wr_count}, {24'h0, e.cnt});
      end
    end
  end

  initial begin
    int waited;
    model_clear();
    bus.wb_en    = 1'b0;
    bus.wb_dest  = '0;
    bus.wb_data  = '0;
    bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;

    step(1, 0, 0, 0, 0, 1, "reset");
    step(1, 0, 0, 0, 14, 15, "reset");

    // Write R3 then read it back with a neighbour.
    step(0, 1, 3, 32'hDEADBEEF, 3, 4, "wr_r3");
    step(0, 0, 0, 0, 3, 4, "rd_r3");
    step(0, 1, 5, 32'h55AA0001, 5, 3, "wr_r5");
    step(0, 1, 9, 32'h0BADF00D, 9, 5, "wr_r9");
    step(0, 0, 0, 0, 9, 9, "same_reg");

    // Reset mid-run, sweep every register while held.
    for (int i = 0; i < 15; i++)
      step(1, 0, 4'(i), 32'hFFFFFFFF, 4'(i), 4'(14 - i), "rst_sweep");

    // PC write attempt: sticky error, nothing else changes.
    step(0, 1, 2, 32'h00002222, 2, 15, "wr_r2");
    step(0, 1, 15, 32'h00001234, 15, 2, "wr_pc");
    step(0, 0, 0, 0, 15, 2, "pc_err_set");
    step(0, 0, 15, 32'h0, 2, 0, "pc_err_hold");

    // Write R7 with a same-cycle read of R7.
    step(0, 1, 7, 32'h11111111, 7, 0, "wr_r7_old");
    step(0, 1, 7, 32'hA5A5A5A5, 7, 7, "wr_r7");
    step(0, 0, 0, 0, 7, 2, "rd_r7");

    // wb_en low: no state change whatever wb_dest says.
    step(0, 0, 2, 32'hFFFFFFFF, 2, 2, "en_low");
    step(0, 0, 0, 0, 2, 7, "en_low_after");

    // Reset wins over a coincident write.
    step(1, 1, 6, 32'hCAFEF00D, 0, 1, "rst_write");
    step(0, 0, 0, 0, 6, 7, "rst_write_after");

    // 256 writes cycling R0..R14: counter wraps to zero.
    for (int i = 0; i < 256; i++)
      step(0, 1, 4'(i % 15), $urandom, 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), "wrap_run");
    for (int i = 0; i < 16; i++)
      step(0, 0, 0, 0, 4'(i), 4'(15 - i), "wrap_sweep");

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 63) == 0)
        step(1, 0, 0, 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rand_rst");
      else
        step(0, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom,
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rand");
    end
    step(0, 0, 0, 0, 0, 0, "idle");

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
